// File: rtl/rom_dl_router.sv
// ROM-download router: decodes the ioctl byte stream into N_REGIONS regions, issues
// registered per-region writes, tracks fill counts and a checksum, and gates core reset.
module rom_dl_router #(
  parameter int N_REGIONS = 8,
  parameter int AW        = 25,
  parameter int LAW       = 15,
  parameter logic [N_REGIONS*AW-1:0] REGION_END = {25'h28600, 25'h28400, 25'h28200, 25'h28000,
                                                   25'h20000, 25'h18000, 25'h10000, 25'h08000}
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 ioctl_download_i,
  input  logic                 ioctl_wr_i,
  input  logic [AW-1:0]        ioctl_addr_i,
  input  logic [7:0]           ioctl_dout_i,
  output logic                 dl_wr_o,
  output logic [N_REGIONS-1:0] dl_cs_o,
  output logic [LAW-1:0]       dl_addr_o,
  output logic [7:0]           dl_data_o,
  output logic                 dl_busy_o,
  output logic                 dl_done_o,
  output logic                 dl_err_o,
  output logic [7:0]           dl_sum_o,
  output logic                 core_hold_o
);

  // state | meaning
  // IDLE  | no download since reset
  // LOAD  | download window open, bytes accepted
  // CHECK | one cycle: compare fill counts against region sizes
  // DONE  | image complete and error-free, core released
  // ERR   | image incomplete or illegal, core held
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;

  state_t state_q, state_d;

  logic [AW-1:0]        base_w [N_REGIONS];
  logic [AW-1:0]        end_w  [N_REGIONS];
  logic [AW-1:0]        size_w [N_REGIONS];
  logic [AW-1:0]        cnt_q  [N_REGIONS];
  logic [AW-1:0]        cnt_d  [N_REGIONS];
  logic [AW-1:0]        cnt_base;
  logic [N_REGIONS-1:0] sel_oh;
  logic [LAW-1:0]       local_addr;
  logic                 entry, accept, hit, dup, all_full;

  logic                 wr_q, wr_d;
  logic [N_REGIONS-1:0] cs_q, cs_d;
  logic [LAW-1:0]       addr_q, addr_d;
  logic [7:0]           data_q, data_d;
  logic [7:0]           sum_q, sum_d;
  logic                 err_q, err_d;

  for (genvar g = 0; g < N_REGIONS; g++) begin : g_region
    assign end_w[g] = REGION_END[g*AW +: AW];
    if (g == 0) begin : g_first
      assign base_w[g] = '0;
    end else begin : g_rest
      assign base_w[g] = REGION_END[(g-1)*AW +: AW];
    end
    assign size_w[g] = end_w[g] - base_w[g];
  end

  // Scan from the top so the lowest matching region wins.
  always_comb begin
    sel_oh     = '0;
    local_addr = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if (ioctl_addr_i >= base_w[i] && ioctl_addr_i < end_w[i]) begin
        sel_oh     = '0;
        sel_oh[i]  = 1'b1;
        local_addr = LAW'(ioctl_addr_i - base_w[i]);
      end
    end
  end

  // The entry cycle clears the accumulators yet still accepts its own byte.
  always_comb begin
    entry    = ioctl_download_i && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
    accept   = ioctl_wr_i && (entry || state_q == S_LOAD);
    hit      = |sel_oh;
    dup      = 1'b0;
    cnt_base = '0;
    all_full = 1'b1;
    for (int i = 0; i < N_REGIONS; i++) begin
      cnt_base = entry ? '0 : cnt_q[i];
      cnt_d[i] = cnt_base;
      if (accept && sel_oh[i]) begin
        if (cnt_base == size_w[i]) dup = 1'b1;
        else                       cnt_d[i] = cnt_base + AW'(1);
      end
      if (cnt_q[i] != size_w[i]) all_full = 1'b0;
    end
    wr_d   = accept && hit;
    cs_d   = wr_d ? sel_oh : '0;
    addr_d = wr_d ? local_addr : addr_q;
    data_d = wr_d ? ioctl_dout_i : data_q;
    sum_d  = (entry ? 8'h00 : sum_q) + (wr_d ? ioctl_dout_i : 8'h00);
    err_d  = (entry ? 1'b0 : err_q) | (accept && !hit) | dup;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: if (ioctl_download_i) state_d = S_LOAD;
      S_LOAD:                if (!ioctl_download_i) state_d = S_CHECK;
      S_CHECK:               state_d = (all_full && !err_q) ? S_DONE : S_ERR;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      wr_q    <= 1'b0;
      cs_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      cs_q    <= cs_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
      for (int i = 0; i < N_REGIONS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign dl_wr_o     = wr_q;
  assign dl_cs_o     = cs_q;
  assign dl_addr_o   = addr_q;
  assign dl_data_o   = data_q;
  assign dl_sum_o    = sum_q;
  assign dl_err_o    = err_q;
  assign dl_busy_o   = (state_q == S_LOAD) || (state_q == S_CHECK);
  assign dl_done_o   = (state_q == S_DONE);
  assign core_hold_o = (state_q != S_DONE);

endmodule

// File: tb/tb_rom_dl_router.sv
// Directed bench for rom_dl_router: a scaled-down region map for full-image runs plus a
// default-parameter instance for spot checks of the production address map.
module tb_rom_dl_router;
  localparam int AW = 25;
  localparam int N = 8;
  localparam int LAW = 15;
  localparam int IMG = 'h600;
  localparam logic [N*AW-1:0] SMALL_END = {25'h600, 25'h580, 25'h540, 25'h500,
                                           25'h400, 25'h300, 25'h200, 25'h100};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [AW-1:0] ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;

  logic          dl_wr, dl_busy, dl_done, dl_err, core_hold;
  logic [N-1:0]  dl_cs;
  logic [LAW-1:0] dl_addr;
  logic [7:0]    dl_data, dl_sum;

  logic          d_wr, d_busy, d_done, d_err, d_hold;
  logic [N-1:0]  d_cs;
  logic [LAW-1:0] d_addr;
  logic [7:0]    d_data, d_sum;

  rom_dl_router #(.N_REGIONS(N), .AW(AW), .LAW(LAW), .REGION_END(SMALL_END)) dut (
    .clk_i(clk), .reset_i(reset), .ioctl_download_i(ioctl_download), .ioctl_wr_i(ioctl_wr),
    .ioctl_addr_i(ioctl_addr), .ioctl_dout_i(ioctl_dout),
    .dl_wr_o(dl_wr), .dl_cs_o(dl_cs), .dl_addr_o(dl_addr), .dl_data_o(dl_data),
    .dl_busy_o(dl_busy), .dl_done_o(dl_done), .dl_err_o(dl_err), .dl_sum_o(dl_sum),
    .core_hold_o(core_hold));

  rom_dl_router dut_def (
    .clk_i(clk), .reset_i(reset), .ioctl_download_i(ioctl_download), .ioctl_wr_i(ioctl_wr),
    .ioctl_addr_i(ioctl_addr), .ioctl_dout_i(ioctl_dout),
    .dl_wr_o(d_wr), .dl_cs_o(d_cs), .dl_addr_o(d_addr), .dl_data_o(d_data),
    .dl_busy_o(d_busy), .dl_done_o(d_done), .dl_err_o(d_err), .dl_sum_o(d_sum),
    .core_hold_o(d_hold));

  int n_assert = 0;
  int n_fail = 0;
  int pulses = 0;
  int p0;

  always @(negedge clk) if (dl_wr) pulses++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    @(posedge clk); #1;
    ioctl_wr = 1'b0;
  endtask

  // Sequential image 0..IMG-1 with byte = addr[7:0]; the last byte coincides with the
  // falling download. Optional omitted address and one extra byte after address 0x300.
  task automatic full_load(input int omit, input int extra, input bit entry_byte);
    ioctl_download = 1'b1;
    if (!entry_byte) begin
      @(posedge clk); #1;
    end
    for (int a = 0; a < IMG; a++) begin
      if (a == omit) continue;
      if (a == IMG - 1) ioctl_download = 1'b0;
      send_byte(a[AW-1:0], a[7:0]);
      if (a == 'h000) begin
        chk("busy_in_load", dl_busy, 1);
        chk("done_cleared", dl_done, 0);
        chk("err_cleared", dl_err, 0);
        chk("hold_in_load", core_hold, 1);
      end
      if (a == 'h103) begin
        chk("r1_wr", dl_wr, 1);
        chk("r1_cs", dl_cs, 'h02);
        chk("r1_addr", dl_addr, 'h003);
        chk("r1_data", dl_data, 'h03);
      end
      if (a == 'h581) begin
        chk("r7_cs", dl_cs, 'h80);
        chk("r7_addr", dl_addr, 'h001);
      end
      if (a == 'h300 && extra >= 0) begin
        send_byte(extra[AW-1:0], extra[7:0]);
        if (extra < IMG) begin
          chk("dup_wr", dl_wr, 1);
          chk("dup_cs", dl_cs, 'h01);
          chk("dup_addr", dl_addr, extra);
        end else begin
          chk("oor_wr", dl_wr, 0);
          chk("oor_cs", dl_cs, 0);
        end
      end
    end
    chk("busy_in_check", dl_busy, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_wr", dl_wr, 0);
    chk("rst_cs", dl_cs, 0);
    chk("rst_addr", dl_addr, 0);
    chk("rst_data", dl_data, 0);
    chk("rst_busy", dl_busy, 0);
    chk("rst_done", dl_done, 0);
    chk("rst_err", dl_err, 0);
    chk("rst_sum", dl_sum, 0);
    chk("rst_hold", core_hold, 1);

    // Strobes without a download window are ignored
    p0 = pulses;
    send_byte(25'h103, 8'h11);
    send_byte(25'h000, 8'h22);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_no_wr", pulses - p0, 0);
    chk("idle_hold", core_hold, 1);
    chk("idle_done", dl_done, 0);

    // Complete image, first byte on the entry cycle
    p0 = pulses;
    full_load(-1, -1, 1'b1);
    chk("full_pulses", pulses - p0, IMG);
    chk("full_done", dl_done, 1);
    chk("full_hold", core_hold, 0);
    chk("full_sum", dl_sum, 'h00);
    chk("full_err", dl_err, 0);
    chk("full_busy", dl_busy, 0);

    // Missing byte 0x5A0: incomplete region, no sticky error
    p0 = pulses;
    full_load('h5A0, -1, 1'b0);
    chk("omit_pulses", pulses - p0, IMG - 1);
    chk("omit_done", dl_done, 0);
    chk("omit_err", dl_err, 0);
    chk("omit_hold", core_hold, 1);
    chk("omit_sum", dl_sum, 'h60);

    // Out-of-range byte at the first address past the map
    p0 = pulses;
    full_load(-1, IMG, 1'b0);
    chk("oor_pulses", pulses - p0, IMG);
    chk("oor_done", dl_done, 0);
    chk("oor_err", dl_err, 1);
    chk("oor_hold", core_hold, 1);
    chk("oor_sum", dl_sum, 'h00);

    // Duplicate write into a full region
    p0 = pulses;
    full_load(-1, 'h010, 1'b0);
    chk("dup_pulses", pulses - p0, IMG + 1);
    chk("dup_done", dl_done, 0);
    chk("dup_err", dl_err, 1);
    chk("dup_sum", dl_sum, 'h10);

    // Reset in the middle of a download, then ignored strobe, then full reload
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    for (int a = 0; a < 'h345; a++) send_byte(a[AW-1:0], a[7:0]);
    reset = 1'b1;
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("mid_rst_busy", dl_busy, 0);
    chk("mid_rst_sum", dl_sum, 0);
    chk("mid_rst_err", dl_err, 0);
    chk("mid_rst_done", dl_done, 0);
    chk("mid_rst_hold", core_hold, 1);
    chk("mid_rst_wr", dl_wr, 0);
    chk("mid_rst_cs", dl_cs, 0);
    p0 = pulses;
    send_byte(25'h010, 8'h55);
    chk("mid_rst_ignored", dl_wr, 0);
    p0 = pulses;
    full_load(-1, -1, 1'b1);
    chk("reload_pulses", pulses - p0, IMG);
    chk("reload_done", dl_done, 1);
    chk("reload_hold", core_hold, 0);
    chk("reload_sum", dl_sum, 'h00);
    send_byte(25'h020, 8'h77);
    chk("done_wr_ignored", dl_wr, 0);
    chk("done_stays", dl_done, 1);
    chk("done_sum_kept", dl_sum, 'h00);

    // Production address map spot checks
    ioctl_download = 1'b1;
    @(posedge clk); #1;
    send_byte(25'h08003, 8'hA5);
    chk("def_r1_wr", d_wr, 1);
    chk("def_r1_cs", d_cs, 'h02);
    chk("def_r1_addr", d_addr, 'h0003);
    chk("def_r1_data", d_data, 'hA5);
    send_byte(25'h28401, 8'h5A);
    chk("def_r7_cs", d_cs, 'h80);
    chk("def_r7_addr", d_addr, 'h001);
    send_byte(25'h27FFF, 8'h3C);
    chk("def_r4_cs", d_cs, 'h10);
    chk("def_r4_addr", d_addr, 'h7FFF);
    send_byte(25'h28600, 8'h01);
    chk("def_oor_wr", d_wr, 0);
    chk("def_oor_err", d_err, 1);
    ioctl_download = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("def_err_state_hold", d_hold, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
